// File: rtl/iterative_multiplier.sv
// iterative_multiplier: fixed-latency shift-add unsigned multiplier with start/done handshake
module iterative_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  // state and datapath registers, cleared immediately on reset so an aborted op never signals done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end
  // next state: accept in IDLE, WIDTH shift-add steps in CALC, publish result from FIN
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = CALC;
        mcand_d  = {{WIDTH{1'b0}}, multiplicand};
        mplier_d = multiplier;
        acc_d    = '0;
        cnt_d    = CNT_W'(WIDTH);
      end
      CALC: begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        state_d  = (cnt_q == CNT_W'(1)) ? FIN : CALC;
      end
      FIN: begin
        prod_d  = acc_q;
        ovf_d   = |acc_q[2*WIDTH-1:WIDTH];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign product  = prod_q;
  assign overflow = ovf_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE) || done_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: randomized scoreboard bench against a plain-arithmetic product model
module tb_iterative_multiplier;
  localparam int W = 32;
  localparam int LAT = W + 1;
  typedef struct {
    logic [2*W-1:0] p;
    logic           o;
    int             c;
  } exp_t;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] product;
  logic           overflow, busy, done;
  exp_t           sb[$];
  int             cmp = 0;
  int             mis = 0;
  int             cyc = 0;
  int             done_seen = 0;
  logic [2*W-1:0] last_prod = '0;
  logic           last_ovf = 1'b0;
  logic           prev_done = 1'b0;

  iterative_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t e;
    e.p = (2*W)'(a) * (2*W)'(b);
    e.o = e.p >= (64'd1 << W);
    e.c = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {product[2*W-1:3], product[2:0] | {overflow, busy, done}}, '0);
      last_prod = '0;
      last_ovf = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_single_cycle", 64'(prev_done), 64'd0);
        chk("busy_in_done_cycle", 64'(busy), 64'd1);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", product, e.p);
          chk("overflow", 64'(overflow), 64'(e.o));
          chk("latency", 64'(cyc - e.c), 64'(LAT));
        end
        last_prod = product;
        last_ovf = overflow;
        done_seen++;
      end else begin
        chk("result_stable", {product[2*W-1:1], product[0] ^ overflow}, {last_prod[2*W-1:1], last_prod[0] ^ last_ovf});
        if (sb.size() != 0 && cyc - sb[0].c > LAT + 5) begin
          chk("done_timeout", 64'(cyc - sb[0].c), 64'(LAT));
          void'(sb.pop_front());
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    multiplicand = a;
    multiplier = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sb.push_back(model(a, b, cyc));
    multiplicand = $urandom;
    multiplier = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    do_op(32'd3, 32'd5);
    drain();
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(32'h0001_0000, 32'h0001_0000);
    do_op(32'd0, 32'h1234_5678);
    drain();
    do_op(32'd7, 32'd6);
    repeat (5) @(negedge clk);
    multiplicand = 32'd9;
    multiplier = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    begin
      int base;
      int n;
      wait_idle();
      multiplicand = 32'd2;
      multiplier = 32'd2;
      start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) sb.push_back(model(32'd2, 32'd2, cyc + i * (W + 2)));
      base = done_seen;
      n = 0;
      while (done_seen < base + 3 && n < 200) begin
        @(negedge clk);
        #1 n++;
      end
      start = 1'b0;
      if (done_seen < base + 3) chk("back_to_back_count", 64'(done_seen - base), 64'd3);
      drain();
    end
    do_op(32'd100, 32'd100);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_product", product, '0);
    chk("abort_flags", {61'd0, overflow, busy, done}, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    do_op(32'd100, 32'd100);
    drain();
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      case ($urandom_range(0, 4))
        0: begin a = '0; b = $urandom; end
        1: begin a = '1; b = '1; end
        2: begin a = $urandom; b = 32'(1) << $urandom_range(0, W - 1); end
        3: begin a = 32'($urandom_range(0, 65535)); b = 32'($urandom_range(0, 65535)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      do_op(a, b);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    drain();
    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/iterative_multiplier.md
Name: iterative_multiplier

Overview:
- Multi-cycle shift-add unsigned multiplier; the inverse operation to the team's iterative divider.
- Used in the frequency-counter datapath to scale raw counts, e.g. count × reference-clock ratio, before division or display.
- Start/done handshake with fixed latency, so control FSMs can chain it directly with the divider.
- Full-width 2*WIDTH product, plus an overflow flag for consumers that keep only the lower WIDTH bits.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
multiplicand  input  WIDTH  operand A, unsigned
multiplier  input  WIDTH  operand B, unsigned
product  output  2*WIDTH  A*B; held until next completion
overflow  output  1  product[2*WIDTH-1:WIDTH] nonzero; updated with product
busy  output  1  high from accept until done cycle, inclusive
done  output  1  one-cycle completion pulse

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: product=0, overflow=0, busy=0, done=0. Internal state: IDLE, accumulator 0, counter 0.
- States: IDLE, CALC, FIN.
- IDLE → CALC when start=1 at a rising edge. On that edge:
  - latch mcand_sh = {WIDTH'b0, multiplicand} (2*WIDTH bits) and mplier = multiplier;
  - clear acc (2*WIDTH bits);
  - cnt = WIDTH; busy = 1.
- CALC, each cycle:
  - if mplier[0], acc = acc + mcand_sh, modulo 2^(2*WIDTH); no carry out is possible.
  - mcand_sh <<= 1; mplier >>= 1; cnt = cnt - 1.
  - When cnt reaches 0 after exactly WIDTH iterations, go to FIN.
- No early termination: zero or small operands still take WIDTH iterations (fixed latency).
- FIN, one cycle: product = acc; overflow = |acc[2*WIDTH-1:WIDTH]; done = 1; busy = 1. Next state is IDLE, where busy = 0 and done = 0.
- Latency: start sampled at edge E0 → done high in the cycle following edge E0+WIDTH+1. That is WIDTH+1 cycles after acceptance (33 for default); throughput one op per WIDTH+2 cycles.
- start while busy (CALC or FIN) is ignored, not queued. Operands are latched at accept; later input changes have no effect.
- start may be held high continuously: a new op is accepted on the first IDLE cycle after FIN.
- product and overflow change only in FIN; they are stable otherwise, including during a subsequent operation.
- done is never high for more than one consecutive cycle.
- Reset mid-operation (any state): immediate abort, all outputs to reset values, no done pulse; the next start is accepted normally.
- Results are exact for all operand pairs, including 0 and all-ones (2^WIDTH-1).

Test Plan:
1. Reset then idle: rst_n low for 3 cycles, start=0 → product=0, overflow=0, busy=0, done=0 throughout.
2. A=3, B=5, start pulsed 1 cycle → busy high; done pulse exactly 33 cycles after the accept edge; product=15, overflow=0.
3. A=0xFFFFFFFF, B=0xFFFFFFFF → product=0xFFFFFFFE00000001, overflow=1. Then A=0x10000, B=0x10000 → product=0x1_0000_0000, overflow=1.
4. A=0, B=0x12345678 → product=0, overflow=0, still 33-cycle latency.
5. Accept A=7, B=6; pulse start with A=9, B=9 while busy → single done, product=42; no second done without a new start in IDLE. Then hold start high with A=2, B=2 → back-to-back ops, each done 34 cycles apart, product=4.
6. Assert rst_n low at cycle 10 of a computation of A=100, B=100 → outputs zero immediately, no done. Release reset, start A=100, B=100 → product=10000 after 33 cycles.
